// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: breaks a change amount into 1000/500/100 coins (largest first)
// and ejects them one at a time through a request/acknowledge handshake with the hopper.
module coin_change_dispenser #(
  parameter int unsigned TOTAL_BITS = 32,
  parameter int unsigned COUNT_BITS = 10,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_amount,
  input  logic                  i_clear,
  input  logic                  i_eject_ack,
  output logic [2:0]            o_eject,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [COUNT_BITS-1:0] o_coin_count,
  output logic [TOTAL_BITS-1:0] o_remainder
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [ToW-1:0]  ToLast  = ToW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [TOTAL_BITS-1:0] Coin100  = TOTAL_BITS'(100);
  localparam logic [TOTAL_BITS-1:0] Coin500  = TOTAL_BITS'(500);
  localparam logic [TOTAL_BITS-1:0] Coin1000 = TOTAL_BITS'(1000);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StEject,
    StGap,
    StDone,
    StFault
  } state_e;

  state_e                  state_q;
  logic [2:0]              eject_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    fault_q;
  logic [COUNT_BITS-1:0]   count_q;
  logic [TOTAL_BITS-1:0]   rem_q;
  logic [GapW-1:0]         gap_q;
  logic [ToW-1:0]          to_q;
  logic [TOTAL_BITS-1:0]   coin_val;

  // Value of the coin currently being requested from the hopper.
  always_comb begin
    coin_val = '0;
    unique case (eject_q)
      3'b001:  coin_val = Coin100;
      3'b010:  coin_val = Coin500;
      3'b100:  coin_val = Coin1000;
      default: coin_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      eject_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            rem_q   <= i_amount;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StSelect;
          end
        end

        StSelect: begin
          to_q <= '0;
          if (rem_q >= Coin1000) begin
            eject_q <= 3'b100;
            state_q <= StEject;
          end else if (rem_q >= Coin500) begin
            eject_q <= 3'b010;
            state_q <= StEject;
          end else if (rem_q >= Coin100) begin
            eject_q <= 3'b001;
            state_q <= StEject;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end

        StEject: begin
          // An ack on the final timeout edge still counts the coin.
          if (i_eject_ack) begin
            rem_q   <= rem_q - coin_val;
            if (count_q != '1) begin
              count_q <= count_q + COUNT_BITS'(1);
            end
            eject_q <= '0;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? StSelect : StGap;
          end else if (to_q == ToLast) begin
            eject_q <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= StFault;
          end else begin
            to_q <= to_q + ToW'(1);
          end
        end

        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StSelect;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        StFault: begin
          if (i_clear) begin
            fault_q <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_eject      = eject_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_fault      = fault_q;
  assign o_coin_count = count_q;
  assign o_remainder  = rem_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: table of change transactions plus hand-written
// fault, reset and stray-ack sequences.
module tb_coin_change_dispenser;

  localparam int unsigned Gap = 1;
  localparam int unsigned Timeout = 16;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_amount;
  logic        i_clear;
  logic        i_eject_ack;
  logic [2:0]  o_eject;
  logic        o_busy;
  logic        o_done;
  logic        o_fault;
  logic [9:0]  o_coin_count;
  logic [31:0] o_remainder;

  int n_checks;
  int n_fail;

  coin_change_dispenser #(
    .TOTAL_BITS(32),
    .COUNT_BITS(10),
    .GAP_CYCLES(Gap),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_amount    (i_amount),
    .i_clear     (i_clear),
    .i_eject_ack (i_eject_ack),
    .o_eject     (o_eject),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fault     (o_fault),
    .o_coin_count(o_coin_count),
    .o_remainder (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] amount;
    int          n1000;
    int          n500;
    int          n100;
    int          ack_dly;
    logic        stray;
    int          restart_k;
    logic [31:0] exp_count;
    logic [31:0] exp_rem;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [31:0] amount, input int n1000, input int n500,
                              input int n100, input int ack_dly, input logic stray,
                              input int restart_k, input logic [31:0] exp_count,
                              input logic [31:0] exp_rem);
    vec_t v;
    v.amount    = amount;
    v.n1000     = n1000;
    v.n500      = n500;
    v.n100      = n100;
    v.ack_dly   = ack_dly;
    v.stray     = stray;
    v.restart_k = restart_k;
    v.exp_count = exp_count;
    v.exp_rem   = exp_rem;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one transaction; k counts falling edges after the start-sampling edge.
  task automatic run_vec(input vec_t v);
    int k;
    int wait_c;
    int ncoin;
    int done_k;
    int exp_k;
    logic [2:0] exp_code;
    @(negedge clk);
    i_amount = v.amount;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    k      = 1;
    wait_c = 0;
    ncoin  = 0;
    done_k = 0;
    while (k < 400 && done_k == 0) begin
      if (k == v.restart_k) begin
        i_start  = 1'b1;
        i_amount = 32'd9000;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        done_k = k;
      end else if (o_eject != 3'b000) begin
        if (wait_c == 0) begin
          if (ncoin < v.n1000) exp_code = 3'b100;
          else if (ncoin < v.n1000 + v.n500) exp_code = 3'b010;
          else exp_code = 3'b001;
          chk("coin_order", {29'd0, o_eject}, {29'd0, exp_code});
          ncoin++;
        end
        i_eject_ack = (wait_c == v.ack_dly);
        wait_c++;
      end else begin
        wait_c      = 0;
        i_eject_ack = v.stray;
      end
      if (done_k == 0) begin
        @(negedge clk);
        k++;
      end
    end
    i_eject_ack = 1'b0;
    i_start     = 1'b0;
    exp_k = 2 + int'(v.exp_count) * (2 + int'(Gap) + v.ack_dly);
    chk("done_cycle", done_k, exp_k);
    chk("coins_ejected", ncoin, v.exp_count);
    chk("coin_count", {22'd0, o_coin_count}, v.exp_count);
    chk("remainder", o_remainder, v.exp_rem);
    chk("busy_at_done", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("done_single_pulse", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    chk("count_hold_idle", {22'd0, o_coin_count}, v.exp_count);
    chk("rem_hold_idle", o_remainder, v.exp_rem);
  endtask

  initial begin
    int wait_c;
    int coins;
    int m;
    int fault_m;
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_amount    = 32'd0;
    i_clear     = 1'b0;
    i_eject_ack = 1'b0;

    vecs[0] = mk(32'd5500, 5, 1, 0, 1, 1'b0, 0, 32'd6, 32'd0);
    vecs[1] = mk(32'd700,  0, 1, 2, 0, 1'b0, 0, 32'd3, 32'd0);
    vecs[2] = mk(32'd250,  0, 0, 2, 0, 1'b0, 0, 32'd2, 32'd50);
    vecs[3] = mk(32'd0,    0, 0, 0, 0, 1'b0, 0, 32'd0, 32'd0);
    vecs[4] = mk(32'd1500, 1, 1, 0, 0, 1'b0, 4, 32'd2, 32'd0);
    vecs[5] = mk(32'd1850, 1, 1, 3, 1, 1'b1, 0, 32'd5, 32'd50);
    vecs[6] = mk(32'd99,   0, 0, 0, 0, 1'b0, 0, 32'd0, 32'd99);

    repeat (3) @(negedge clk);
    chk("reset_eject", {29'd0, o_eject}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    chk("reset_fault", {31'd0, o_fault}, 32'd0);
    chk("reset_count", {22'd0, o_coin_count}, 32'd0);
    chk("reset_rem", o_remainder, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Hopper stalls on the third coin of 3000.
    @(negedge clk);
    i_amount = 32'd3000;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_c  = 0;
    coins   = 0;
    m       = -1;
    fault_m = -1;
    for (int k = 0; k < 200 && fault_m < 0; k++) begin
      if (m >= 0) m++;
      if (o_fault) begin
        fault_m = m;
      end else begin
        if (m >= 0 && m < 16) begin
          chk("eject_held_stall", {29'd0, o_eject}, 32'd1 << 2);
        end
        if (o_eject != 3'b000) begin
          if (wait_c == 0) begin
            coins++;
            if (coins == 3) m = 0;
          end
          i_eject_ack = (coins < 3 && wait_c == 0);
          wait_c++;
        end else begin
          wait_c      = 0;
          i_eject_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    i_eject_ack = 1'b0;
    chk("fault_latency", fault_m, Timeout);
    chk("fault_count", {22'd0, o_coin_count}, 32'd2);
    chk("fault_rem", o_remainder, 32'd1000);
    chk("fault_busy", {31'd0, o_busy}, 32'd0);
    chk("fault_eject", {29'd0, o_eject}, 32'd0);

    i_amount = 32'd500;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("fault_sticky", {31'd0, o_fault}, 32'd1);
    chk("fault_start_ignored_busy", {31'd0, o_busy}, 32'd0);
    chk("fault_start_ignored_rem", o_remainder, 32'd1000);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    chk("fault_cleared", {31'd0, o_fault}, 32'd0);
    run_vec(mk(32'd600, 0, 1, 1, 0, 1'b0, 0, 32'd2, 32'd0));

    // Reset while the second coin of 2000 is in flight.
    @(negedge clk);
    i_amount = 32'd2000;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    coins   = 0;
    wait_c  = 0;
    for (int k = 0; k < 100 && coins < 2; k++) begin
      if (o_eject != 3'b000) begin
        if (wait_c == 0) coins++;
        i_eject_ack = (coins < 2 && wait_c == 0);
        wait_c++;
      end else begin
        wait_c      = 0;
        i_eject_ack = 1'b0;
      end
      if (coins < 2) @(negedge clk);
    end
    i_eject_ack = 1'b0;
    chk("pre_reset_count", {22'd0, o_coin_count}, 32'd1);
    chk("pre_reset_eject", {29'd0, o_eject}, 32'd4);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midreset_eject", {29'd0, o_eject}, 32'd0);
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    chk("midreset_count", {22'd0, o_coin_count}, 32'd0);
    chk("midreset_rem", o_remainder, 32'd0);

    i_eject_ack = 1'b1;
    repeat (3) @(negedge clk);
    i_eject_ack = 1'b0;
    chk("stray_ack_count", {22'd0, o_coin_count}, 32'd0);
    chk("stray_ack_busy", {31'd0, o_busy}, 32'd0);
    chk("stray_ack_rem", o_remainder, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

Downstream stage of the vending machine controller. Converts a returned-change amount into a sequence of physical coin ejections: greedy 1000/500/100 decomposition, one coin at a time, with a request/acknowledge handshake to the coin hopper. Reports coins dispensed, the undispensable remainder, and hopper faults back to the controller.

## Interface
Parameters:
- TOTAL_BITS, 32, width of amount and remainder (matches controller current-total width)
- COUNT_BITS, 10, width of coin counter (matches controller return-coin width)
- GAP_CYCLES, 1, idle cycles inserted between consecutive ejections (0 allowed)
- TIMEOUT, 16, max cycles spent in EJECT waiting for ack before fault (≥1)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- i_start  input  1  one-cycle pulse: latch i_amount and begin dispensing
- i_amount  input  TOTAL_BITS  change amount to dispense
- i_clear  input  1  clears a latched fault
- i_eject_ack  input  1  hopper acknowledges the currently requested coin
- o_eject  output  3  one-hot coin request held until ack: [0]=100, [1]=500, [2]=1000
- o_busy  output  1  high from the cycle after start acceptance until DONE/FAULT
- o_done  output  1  one-cycle pulse on completion
- o_fault  output  1  sticky hopper-timeout flag
- o_coin_count  output  COUNT_BITS  coins ejected in current/last transaction
- o_remainder  output  TOTAL_BITS  amount still owed (final value <100 after DONE)

## Operation
- States: IDLE, SELECT, EJECT, GAP, DONE, FAULT. All outputs registered.
- IDLE: i_start sampled high → latch remainder=i_amount, count=0, busy=1, next SELECT. i_start ignored in every other state.
- SELECT (1 cycle): remainder≥1000 → request 1000; else ≥500 → 500; else ≥100 → 100; else → DONE. A request sets o_eject one-hot and enters EJECT with timeout counter cleared.
- EJECT: each edge with i_eject_ack=1 → remainder -= coin value, count += 1, o_eject=0, next GAP (or SELECT if GAP_CYCLES=0). Without ack, timeout counter increments; when TIMEOUT cycles have elapsed in EJECT without ack → o_eject=0, busy=0, fault=1, next FAULT. Remainder/count not updated for the unacknowledged coin.
- GAP: stay GAP_CYCLES cycles, then SELECT.
- DONE: o_done=1 for exactly this cycle, busy=0, next IDLE.
- FAULT: held until i_clear sampled high → fault=0, next IDLE. i_start ignored while in FAULT.
- i_eject_ack while o_eject=0 is ignored.
- Count saturates at all-ones (no wrap). Remainder never underflows (greedy choice guarantees it).
- o_coin_count and o_remainder hold their final values in IDLE until the next accepted i_start.
- i_amount not a multiple of 100: dispense floor; residue stays in o_remainder.

## Timing
- Reset (reset_n low at an edge): state IDLE; o_eject=0, o_busy=0, o_done=0, o_fault=0, o_coin_count=0, o_remainder=0. Applies mid-transaction; the coin in flight is abandoned without a count update.
- Start edge E: busy=1 and state SELECT visible after E; o_eject asserted after E+1.
- Ack sampled at the first EJECT edge: per-coin cost = 2 + GAP_CYCLES cycles.
- After the last coin: GAP, then SELECT (1 cycle), then o_done high for one cycle.
- Zero-coin transaction (i_amount<100): o_done high in the 2nd cycle after the start edge, o_eject never asserted.
- Fault: o_fault rises exactly TIMEOUT cycles after o_eject first asserts (ack low throughout).

## Test plan
- Amount 5500, GAP_CYCLES=1, ack one cycle after each request → ejects 1000×5 then 500×1, o_coin_count=6, o_remainder=0, single o_done pulse, o_busy low afterwards.
- Amount 700 → 500, 100, 100 in that order, count=3, remainder=0. Amount 250 → 100, 100, count=2, remainder=50.
- Amount 0 → no o_eject, o_done 2 cycles after start, count=0. A second i_start during a 1500 transaction → ignored, totals unaffected.
- Ack withheld on the 3rd coin of 3000 → o_fault after TIMEOUT cycles, count=2, remainder=1000, busy=0. i_start ignored until i_clear; afterward a new transaction runs normally.
- reset_n low while dispensing 2000 (after 1st ack) → next edge all outputs 0, state IDLE. Ack pulses with o_eject=0 → no count change.
